alu_share_ctrl: RTL and testbench

Two-requester front end that time-shares the single 16-bit ALU between two masters (e.g. main datapath and address-generation unit). Round-robin arbitration with valid/ready handshakes on request and response. Operands are registered, the ALU result is registered, and the response is held until accepted. Also flags unsupported opcodes and counts completed operations.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 22 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/alu_share_ctrl.sv | 111 +++++++++++
 tb/tb_alu_share_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester front end: widths,
// ALU_CTRL opcodes, controller states and the opcode legality test.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b1010;
  localparam logic [OP_W-1:0] OP_SLT = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// 16-bit ALU: add/sub wrap modulo 2^16, slt is an unsigned compare.
// Any other control code yields 16'h0001.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = DATA_W'(1);
    case (alu_ctrl)
      OP_ADD:  result = src1 + src2;
      OP_SUB:  result = src1 - src2;
      OP_SLT:  result = (src1 < src2) ? DATA_W'(1) : '0;
      default: result = DATA_W'(1);
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. last_grant resets to 1 so requester 0 wins
// the first tie; it only moves when a grant is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters: round-robin grant in IDLE,
// registered operands in EXEC, registered result held in RESP until accepted.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_err,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state, state_nxt;
  logic [1:0]        gnt;
  logic              accept;
  logic              resp_accept;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] src1_q, src2_q;
  logic              id_q;
  logic [DATA_W-1:0] alu_out;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  alu u_alu (
    .alu_ctrl (op_q),
    .src1     (src1_q),
    .src2     (src2_q),
    .result   (alu_out)
  );

  // Readies are gated by rst_n so they read 0 for the whole reset pulse,
  // even though IDLE plus a valid request would otherwise produce a grant.
  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    accept      = 1'b0;
    resp_accept = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = gnt[0] & rst_n;
        req1_ready = gnt[1] & rst_n;
        accept     = (gnt != 2'b00) & rst_n;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        resp0_valid = ~id_q;
        resp1_valid = id_q;
        resp_accept = id_q ? resp1_ready : resp0_ready;
        if (resp_accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      id_q        <= 1'b0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      op_count    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= gnt[1] ? req1_op   : req0_op;
        src1_q <= gnt[1] ? req1_src1 : req0_src1;
        src2_q <= gnt[1] ? req1_src2 : req0_src2;
        id_q   <= gnt[1];
      end
      if (state == EXEC) begin
        resp_result <= alu_out;
        resp_err    <= ~op_legal(op_q);
      end
      if (resp_accept && (op_count != '1)) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a transaction-level model checked every
// cycle, plus literal expectations taken from hand-computed results.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [15:0] resp_result;
  logic        resp_err;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DATA_W(16), .OP_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_err(resp_err), .op_count(op_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction model: at most one operation in flight, result due two
  // cycles after its request handshake.
  logic        m_pend;
  int          m_age, m_id, m_last;
  logic [15:0] m_res, m_count;
  logic        m_err;
  int          glog[$];
  logic [15:0] rres_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned s;
    case (op)
      4'b0010: begin s = int'(a) + int'(b); return s[15:0]; end
      4'b1010: begin s = 32'h10000 + int'(a) - int'(b); return s[15:0]; end
      4'b1011: return (int'(a) < int'(b)) ? 16'd1 : 16'd0;
      default: return 16'd1;
    endcase
  endfunction

  task automatic model_cycle();
    int g;
    if (!rst_n) begin
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_resp0_valid", resp0_valid, 0);
      check("rst_resp1_valid", resp1_valid, 0);
      check("rst_op_count", op_count, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_result", resp_result, 0);
      m_pend = 1'b0; m_count = 16'd0; m_last = 1;
      return;
    end
    check("m_op_count", op_count, m_count);
    if (m_pend) begin
      m_age++;
      check("m_busy_req0_ready", req0_ready, 0);
      check("m_busy_req1_ready", req1_ready, 0);
      if (m_age == 1) begin
        check("m_exec_resp0_valid", resp0_valid, 0);
        check("m_exec_resp1_valid", resp1_valid, 0);
      end else begin
        check("m_resp0_valid", resp0_valid, (m_id == 0));
        check("m_resp1_valid", resp1_valid, (m_id == 1));
        check("m_resp_result", resp_result, m_res);
        check("m_resp_err", resp_err, m_err);
        if ((m_id == 0) ? resp0_ready : resp1_ready) begin
          m_pend = 1'b0;
          if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          rres_q.push_back(m_res);
        end
      end
    end else begin
      check("m_idle_resp0_valid", resp0_valid, 0);
      check("m_idle_resp1_valid", resp1_valid, 0);
      g = -1;
      if (req0_valid && (!req1_valid || m_last == 1)) g = 0;
      else if (req1_valid) g = 1;
      check("m_req0_ready", req0_ready, (g == 0));
      check("m_req1_ready", req1_ready, (g == 1));
      if (g >= 0) begin
        m_pend = 1'b1; m_age = 0; m_id = g; m_last = g;
        if (g == 0) begin
          m_res = alu_ref(req0_op, req0_src1, req0_src2);
          m_err = !(req0_op inside {4'b0010, 4'b1010, 4'b1011});
        end else begin
          m_res = alu_ref(req1_op, req1_src1, req1_src2);
          m_err = !(req1_op inside {4'b0010, 4'b1010, 4'b1011});
        end
        glog.push_back(g);
      end
    end
  endtask

  // One clock: model compare on the falling edge, return 1 time unit after
  // the rising edge with outputs settled for the new cycle.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic do_op(input int id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_r, input logic exp_e,
                       input string name);
    int n;
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b;
    end
    #1;
    n = 0;
    while (!((id == 0) ? req0_ready : req1_ready) && n < 20) begin tick(); n++; end
    check({name, "_grant_timeout"}, (n < 20), 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (!((id == 0) ? resp0_valid : resp1_valid) && n < 10) begin tick(); n++; end
    check({name, "_resp_timeout"}, (n < 10), 1);
    check({name, "_result"}, resp_result, exp_r);
    check({name, "_err"}, resp_err, exp_e);
    tick();
  endtask

  logic [3:0]  t_op [4];
  logic [15:0] t_a  [4];
  logic [15:0] t_b  [4];
  logic [15:0] t_r  [4];

  initial begin
    int s0, s1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_src1 = '0; req0_src2 = '0;
    req1_valid = 1'b0; req1_op = '0; req1_src1 = '0; req1_src2 = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    m_pend = 1'b0; m_age = 0; m_id = 0; m_last = 1; m_res = '0; m_err = 1'b0; m_count = '0;

    // Reset state
    do_reset();
    check("reset_result", resp_result, 16'h0000);
    check("reset_count", op_count, 16'd0);

    // 1: single add from requester 0
    req0_valid = 1'b1; req0_op = 4'b0010; req0_src1 = 16'h0003; req0_src2 = 16'h0004;
    #1;
    check("t1_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("t1_exec_no_valid", resp0_valid, 0);
    tick();
    check("t1_resp0_valid", resp0_valid, 1);
    check("t1_result", resp_result, 16'h0007);
    check("t1_err", resp_err, 0);
    tick();
    check("t1_count", op_count, 16'd1);
    check("t1_valid_dropped", resp0_valid, 0);

    // 2: both requesters valid from reset, strict alternation
    do_reset();
    glog.delete(); rres_q.delete();
    req0_valid = 1'b1; req0_op = 4'b1010; req0_src1 = 16'hFFFF; req0_src2 = 16'h0001;
    req1_valid = 1'b1; req1_op = 4'b1011; req1_src1 = 16'h0002; req1_src2 = 16'h0005;
    #1;
    check("t2_first_req0", req0_ready, 1);
    check("t2_first_req1", req1_ready, 0);
    s0 = 0; s1 = 0;
    for (int n = 0; n < 60 && !(s0 == 4 && s1 == 4); n++) begin
      if (req0_valid && req0_ready) s0++;
      if (req1_valid && req1_ready) s1++;
      tick();
      if (s0 == 4) req0_valid = 1'b0;
      if (s1 == 4) req1_valid = 1'b0;
      #1;
    end
    check("t2_served0", s0, 4);
    check("t2_served1", s1, 4);
    repeat (3) tick();
    check("t2_grants", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) check("t2_alternate", glog[i], i % 2);
    if (rres_q.size() >= 2) begin
      check("t2_first_result", rres_q[0], 16'hFFFE);
      check("t2_second_result", rres_q[1], 16'h0001);
    end else begin
      check("t2_response_count", rres_q.size(), 8);
    end
    check("t2_count", op_count, 16'd8);

    // 3: wrap and unsigned compare boundaries
    t_op[0] = 4'b0010; t_a[0] = 16'hFFFF; t_b[0] = 16'h0001; t_r[0] = 16'h0000;
    t_op[1] = 4'b1010; t_a[1] = 16'h0000; t_b[1] = 16'h0001; t_r[1] = 16'hFFFF;
    t_op[2] = 4'b1011; t_a[2] = 16'h8000; t_b[2] = 16'h0001; t_r[2] = 16'h0000;
    t_op[3] = 4'b1011; t_a[3] = 16'h0001; t_b[3] = 16'h8000; t_r[3] = 16'h0001;
    for (int i = 0; i < 4; i++) do_op(0, t_op[i], t_a[i], t_b[i], t_r[i], 1'b0, "t3");

    // 4: illegal opcode on requester 1
    do_op(1, 4'b0000, 16'h1234, 16'h5678, 16'h0001, 1'b1, "t4");
    check("t4_count", op_count, 16'd13);

    // 5: response backpressure with requester 1 waiting
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_src1 = 16'h1234; req0_src2 = 16'h1111;
    #1;
    check("t5_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b1010; req1_src1 = 16'h0010; req1_src2 = 16'h0001;
    #1;
    check("t5_exec_req1_ready", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", resp0_valid, 1);
      check("t5_hold_result", resp_result, 16'h2345);
      check("t5_hold_req1_ready", req1_ready, 0);
      tick();
    end
    resp0_ready = 1'b1;
    #1;
    check("t5_resp_cycle_req1_ready", req1_ready, 0);
    tick();
    check("t5_req1_granted", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("t5_resp1_result", resp_result, 16'h000F);
    tick();
    check("t5_count", op_count, 16'd15);

    // 6a: reset during EXEC
    req0_valid = 1'b1; req0_op = 4'b0010; req0_src1 = 16'h0001; req0_src2 = 16'h0001;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_src1 = 16'h0002; req1_src2 = 16'h0002;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6a_req0_ready", req0_ready, 0);
    check("t6a_req1_ready", req1_ready, 0);
    check("t6a_resp0_valid", resp0_valid, 0);
    check("t6a_resp1_valid", resp1_valid, 0);
    check("t6a_count", op_count, 16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6a_tie_req0", req0_ready, 1);
    check("t6a_tie_req1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    // 6b: reset during RESP
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b1010; req0_src1 = 16'h0009; req0_src2 = 16'h0004;
    tick();
    req0_valid = 1'b0;
    tick();
    check("t6b_in_resp", resp0_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6b_resp0_valid", resp0_valid, 0);
    check("t6b_count", op_count, 16'd0);
    check("t6b_err", resp_err, 0);
    tick();
    rst_n = 1'b1;
    resp0_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t6b_tie_req0", req0_ready, 1);
    check("t6b_tie_req1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
    check("t6b_count_after", op_count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
